// File: rtl/fetch.sv
// rtl/fetch.sv - RV32I instruction fetch stage with prefetch queue
//
// Purpose: holds the PC, addresses a combinational-read instruction memory,
// and queues {pc, ins} pairs for decode. Execute redirects flush the queue.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_addr           byte address to instruction memory (the PC register)
//   imem_data           instruction word at imem_addr, same cycle
//   redirect_valid/pc   new PC request from execute (highest priority)
//   out_valid/ins/pc    queue head towards decode
//   out_ready           decode accepts the head this cycle
//   fetch_fault         sticky misaligned/out-of-range PC flag
module fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 4,
   parameter int          MEM_BYTES = 400
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_ins,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   output logic        fetch_fault
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [31:0]   LAST_PC = 32'(MEM_BYTES - 4);

   logic [31:0]   pc_q, pc_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] count_q, count_d;
   logic          fault_q, fault_d;
   logic [31:0]   mem_pc_q  [DEPTH];
   logic [31:0]   mem_ins_q [DEPTH];

   logic pop, push, ok;

   assign imem_addr   = pc_q;
   assign fetch_fault = fault_q;
   // Gated by redirect so decode never consumes an entry that is being flushed.
   assign out_valid   = (count_q != '0) & ~redirect_valid;
   assign out_ins     = mem_ins_q[rd_q];
   assign out_pc      = mem_pc_q[rd_q];

   always_comb begin
      pop  = out_valid & out_ready;
      ok   = ~fault_q & (pc_q[1:0] == 2'b00) & (pc_q <= LAST_PC);
      // A pop in the same cycle frees a slot, so a full queue can still accept.
      push = ok & ~redirect_valid & ((count_q < DEPTH_C) | pop);

      pc_d    = pc_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      fault_d = fault_q;

      if (redirect_valid) begin
         pc_d    = redirect_pc;
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
         fault_d = 1'b0;
      end else begin
         if (push) begin
            pc_d = pc_q + 32'd4;
            wr_d = wr_q + PW'(1);
         end
         if (pop) begin
            rd_d = rd_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
         if (!ok) begin
            fault_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         fault_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_q[i]  <= '0;
            mem_ins_q[i] <= '0;
         end
      end else begin
         pc_q    <= pc_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         fault_q <= fault_d;
         if (push) begin
            mem_pc_q[wr_q]  <= pc_q;
            mem_ins_q[wr_q] <= imem_data;
         end
      end
   end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage of the single-issue RV32I core. Holds the program counter, drives the combinational-read instruction memory's byte address, and captures the returned 32-bit little-endian word with its PC into a small prefetch queue. The queue feeds decode over a valid/ready handshake, and execute redirects the stream on taken branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- DEPTH, 4: prefetch queue entries (power of two, ≥2).
- MEM_BYTES, 400: instruction memory size in bytes; fetch addresses must satisfy addr+3 < MEM_BYTES.

- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_addr  out  32  byte address to instruction memory; equals the PC register.
- imem_data  in  32  instruction word for imem_addr, valid in the same cycle.
- redirect_valid  in  1  execute requests a new PC this cycle.
- redirect_pc  in  32  target PC for the redirect.
- out_valid  out  1  queue head holds an instruction for decode.
- out_ins  out  32  head instruction.
- out_pc  out  32  head PC.
- out_ready  in  1  decode accepts the head this cycle.
- fetch_fault  out  1  sticky flag: PC misaligned or out of range; fetch halted.

## Operation
- State: pc[31:0], a circular queue of DEPTH entries of {pc, ins}, rd_ptr and wr_ptr of log2(DEPTH) bits each, count of log2(DEPTH)+1 bits, and fault.
- pop = out_valid & out_ready.
- ok = ~fault, pc[1:0]==0, and pc ≤ MEM_BYTES-4.
- push = ok & ~redirect_valid & (count<DEPTH | pop).
- On push, write {pc, imem_data} at wr_ptr, advance wr_ptr with wrap, and set pc ← pc+4 (32-bit modulo).
- If ok is false and there is no redirect, set fault ← 1, hold pc, and do not enqueue.
- count ← count + push − pop. Push and pop together are legal when the queue is full and when it holds one entry.
- out_valid = (count≠0) & ~redirect_valid. This is combinational, so decode never consumes an instruction in a redirect cycle.
- out_ins and out_pc come from the entry at rd_ptr. Storage resets to 0.
- Redirect has the highest priority. At the edge: count ← 0, rd_ptr ← wr_ptr ← 0, pc ← redirect_pc, fault ← 0.
  - There is no fetch in the redirect cycle.
  - A misaligned or out-of-range redirect_pc sets fault on the next cycle through the ok check.
- Reset mid-operation discards all queued entries immediately.

## Timing
- Reset values: imem_addr=RESET_PC, out_valid=0, out_ins=0, out_pc=0, fetch_fault=0, count=0.
- Fetch to decode latency is 1 cycle. A word addressed in cycle N is visible at the head in cycle N+1 if the queue was empty. There is no empty-queue bypass.
- Sustained throughput is 1 instruction per cycle while out_ready=1.
- Redirect asserted in cycle N:
  - imem_addr=redirect_pc in N+1.
  - The first post-redirect instruction is valid in N+2.
- Full queue with out_ready=0: pc and imem_addr hold and nothing is lost.
- fetch_fault rises one cycle after the offending PC is presented. It stays high until a redirect or reset. Queued entries still drain.

## Test plan
- Reset then release with out_ready=1 over the standard program.
  - Cycle 1: out_pc=0, out_ins=32'h0020_0093.
  - Cycle 2: out_pc=4, out_ins=32'h0010_2023.
  - The PC then advances by 4 every cycle.
- Backpressure: out_ready=0 for 8 cycles from reset.
  - count saturates at 4 and imem_addr holds at 16.
  - Releasing out_ready delivers pcs 0, 4, 8, 12, 16 in order with no gaps or duplicates.
- Redirect with a full queue: redirect_valid=1, redirect_pc=80.
  - out_valid is 0 in the redirect cycle and the cycle after.
  - The next head has out_pc=80 and out_ins=32'h0001_2183.
  - The stale entries are never delivered.
- Simultaneous push and pop at full: toggle out_ready 1/0 each cycle.
  - The delivered PC sequence stays strictly +4 and count never exceeds 4.
- Bounds: redirect_pc=396 with MEM_BYTES=400.
  - The word at 396 is fetched.
  - pc=400 raises fetch_fault and imem_addr holds at 400.
  - A later redirect to 0 clears the fault.
  - Separately, redirect_pc=2 raises the fault with no enqueue.
- Assert rst_n low mid-stream with the queue holding 3 entries.
  - out_valid drops to 0 immediately and imem_addr goes to RESET_PC.
  - After release, delivery restarts at pc 0.
